// File: rtl/ldl_fifo_ws_if.sv
// Write-side FIFO bus: producer handshake, RAM write port and pointer exchange
// with the read-side controller. The controller sits on the slave modport.
interface ldl_fifo_ws_if #(
    parameter int unsigned AW = 8
);
    logic          we;
    logic          full;
    logic          afull;
    logic [AW-1:0] wa;
    logic          mw;
    logic [AW:0]   w_pt;
    logic [AW:0]   r_pt;
    logic [AW:0]   wcnt;
    logic          ovf;
    logic          ovf_clr;

    modport master (
        output we, r_pt, ovf_clr,
        input  full, afull, wa, mw, w_pt, wcnt, ovf
    );

    modport slave (
        input  we, r_pt, ovf_clr,
        output full, afull, wa, mw, w_pt, wcnt, ovf
    );
endinterface

// File: rtl/ldl_fifo_ws.sv
// Write-side pointer/flag controller for the single-clock split FIFO: owns
// w_pt, drives the RAM write port, registered full/afull and sticky overflow.
module ldl_fifo_ws #(
    parameter int unsigned AW       = 8,
    parameter int unsigned AFULL_TH = 2**AW - 1
) (
    input  logic           clk,
    input  logic           rst_n,
    ldl_fifo_ws_if.slave   bus
);
    localparam logic [AW+1:0] C_DEPTH = (AW+2)'(2**AW);
    localparam logic [AW+1:0] C_AFTH  = (AW+2)'(AFULL_TH);

    logic [AW:0]   r_wpt;
    logic          r_full;
    logic          r_afull;
    logic          r_ovf;

    logic [AW:0]   w_occ;
    logic [AW+1:0] w_occ_n;
    logic          w_fw;

    assign w_occ   = r_wpt - bus.r_pt;
    // rst_n gate keeps the RAM strobe quiet while reset is held
    assign w_fw    = bus.we & ~r_full & rst_n;
    assign w_occ_n = {1'b0, w_occ} + {{(AW+1){1'b0}}, w_fw};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wpt   <= '0;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_fw) begin
                r_wpt <= r_wpt + 1'b1;
            end
            r_full  <= (w_occ_n >= C_DEPTH);
            r_afull <= (w_occ_n >= C_AFTH);
            if (bus.we & r_full) begin
                r_ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.full  = r_full;
    assign bus.afull = r_afull;
    assign bus.wa    = r_wpt[AW-1:0];
    assign bus.mw    = w_fw;
    assign bus.w_pt  = r_wpt;
    assign bus.wcnt  = w_occ;
    assign bus.ovf   = r_ovf;
endmodule

// File: doc/ldl_fifo_ws.md
# ldl_fifo_ws

Write-side pointer and flag controller for the single-clock split FIFO. It sits directly upstream of the read-side controller: it owns the write pointer `w_pt` that the read side consumes and takes back the read side's `r_pt`. It also drives the storage RAM write port, and generates registered `full`/`afull` flags and a sticky overflow error.

## Interface
- `AW`, 8, RAM address width; depth `DEPTH = 2**AW`; pointers are AW+1 bits (MSB = wrap bit).
- `AFULL_TH`, `2**AW - 1`, almost-full threshold in entries, legal range 1..DEPTH.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `we`  in  1  write request from producer.
- `full`  out  1  registered; producer must not rely on writes while high.
- `afull`  out  1  registered; occupancy at/above `AFULL_TH`.
- `wa`  out  AW  RAM write address.
- `mw`  out  1  RAM write strobe (accepted write).
- `w_pt`  out  AW+1  registered write pointer, to read side.
- `r_pt`  in  AW+1  read pointer from read side.
- `wcnt`  out  AW+1  current occupancy.
- `ovf`  out  1  sticky overflow error.
- `ovf_clr`  in  1  synchronous clear of `ovf`.

## Operation
- Occupancy: `occ = (w_pt - r_pt)` modulo 2^(AW+1), full AW+1 bits, never truncated; `wcnt = occ` (combinational).
- Accepted write: `fw = we & ~full`; `mw = fw`; `wa = w_pt[AW-1:0]` (combinational from register, no lookahead).
- On `fw`: `w_pt <= w_pt + 1`, natural wrap at 2^(AW+1).
- Next occupancy `occ_n = occ + fw` (AW+2 bits internal so no overflow in compare).
- `full <= (occ_n >= DEPTH)`; `afull <= (occ_n >= AFULL_TH)`.
- The flags are pessimistic: a read in the same cycle is not visible until `r_pt` updates. `full` therefore drops one cycle after the read side advances `r_pt`. It never drops early.
- Illegal `occ > DEPTH` (read side ran ahead): `full` and `afull` assert and stay asserted while the condition holds; no write is accepted.
- `ovf`: set when `we & full`; the write is dropped (`mw = 0`, `w_pt` unchanged). `ovf_clr` clears it. Simultaneous set and clear: set wins.
- No state machine beyond the pointer/flag registers. Reset at any time aborts immediately; a write in flight that cycle is lost.

## Timing
- Reset values: `w_pt = 0`, `full = 0`, `afull = 0`, `ovf = 0`. Therefore `wa = 0`, `mw = 0` while in reset, and `wcnt = 0 - r_pt`.
- Write latency: `mw`/`wa` are valid in the same cycle as `we`. `w_pt` reflects the write at the next edge, so the read side sees new data one cycle after the RAM write.
- Flag latency: `full`/`afull` update on the edge that accepts the write that reaches the threshold.
  - Back-to-back writes can fill to exactly DEPTH with no gap.
  - The write after the filling one is refused.
- Release of `full`: one cycle after `r_pt` changes.
- Sustained throughput: one write per cycle while `full = 0`.
- Simultaneous read and write at full: the write is refused that cycle and accepted the cycle after.

## Test plan
- Reset and idle, AW=2, AFULL_TH=3: deassert `rst_n`, hold `we = 0` -> `w_pt = 0`, `full = 0`, `afull = 0`, `ovf = 0`, `wcnt = 0`.
- Fill, AW=2, AFULL_TH=3, `r_pt = 0`, four consecutive `we` -> `wa = 0, 1, 2, 3`, `mw = 1` each cycle.
  - `afull` rises after the 3rd accept; `full` rises after the 4th.
  - Ends with `w_pt = 4`, `wcnt = 4`.
- Overflow: from full, `we = 1` for 2 cycles -> `mw = 0`, `w_pt` stays 4, `ovf = 1`.
  - Pulse `ovf_clr` with `we = 0` -> `ovf = 0`.
  - `ovf_clr` together with `we = 1` while full -> `ovf` stays 1.
- Release latency: from full, step `r_pt` 0 -> 1.
  - `full` drops exactly one cycle later.
  - A `we` held high throughout gets `mw = 1` on that cycle with `wa = 0`, and `w_pt` becomes 5.
- Wrap: stream 20 writes, with `r_pt` tracking `w_pt` two cycles behind.
  - `w_pt` wraps 7 -> 0.
  - `wa` cycles 0..3.
  - `full` never asserts and `wcnt` stays ≤ 2.
- Async reset mid-operation: assert `rst_n = 0` between edges while full with `ovf = 1`.
  - All outputs reach reset values immediately, before the next edge.
  - The first write after release gets `wa = 0`.
